// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request controllers: FSM encoding, strobe constants
// and the data-width to byte-enable-width mapping.
package sram_ctrl_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int BE_W_DEF = 4;
  localparam logic [BE_W_DEF-1:0] BE_ALL = '1;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-lane merge: each lane takes the new byte where its strobe is set, else keeps the old byte.
module sram_byte_merge #(
  parameter int BE_W   = 4,
  parameter int DATA_W = 8 * BE_W
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_rmw_initiator.sv
// Single-outstanding initiator for the 512x32 SRAM wrapper; partial-byte writes
// are turned into read-modify-write sequences since the macro only has a word write enable.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read strobe on the SRAM port
// CAPT  | SRAM data returning; capture it, merge for partial writes
// WR    | write strobe on the SRAM port
// RESP  | response held until rsp_ready
module sram_rmw_initiator
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int BE_W   = be_width(DATA_W),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  rmw_count
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] q_addr;
  logic              q_we;
  logic [BE_W-1:0]   q_be;
  logic [DATA_W-1:0] q_wdata;
  logic [DATA_W-1:0] merged;
  logic              req_partial;
  logic              q_partial;

  assign req_ready   = (state == S_IDLE) && !reset;
  assign req_partial = req_we && (|req_be) && !(&req_be);
  assign q_partial   = q_we && (|q_be) && !(&q_be);

  sram_byte_merge #(.BE_W(BE_W), .DATA_W(DATA_W)) u_merge (
    .old_word (mem_rdata),
    .new_word (q_wdata),
    .be       (q_be),
    .merged   (merged)
  );

  // Strobes are registered from the transition into RD/WR so they appear the cycle after the decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      q_addr    <= '0;
      q_we      <= 1'b0;
      q_be      <= '0;
      q_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rmw_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            q_addr  <= req_addr;
            q_we    <= req_we;
            q_be    <= req_be;
            q_wdata <= req_wdata;
            if (!req_we || req_partial) begin
              state    <= S_RD;
              mem_en   <= 1'b1;
              mem_wen  <= 1'b0;
              mem_addr <= req_addr;
            end else if (&req_be) begin
              state     <= S_WR;
              mem_en    <= 1'b1;
              mem_wen   <= 1'b1;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              rsp_rdata <= '0;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        S_RD: begin
          state   <= S_CAPT;
          mem_en  <= 1'b0;
          mem_wen <= 1'b0;
        end
        S_CAPT: begin
          rsp_rdata <= mem_rdata;
          if (q_we) begin
            state     <= S_WR;
            mem_en    <= 1'b1;
            mem_wen   <= 1'b1;
            mem_addr  <= q_addr;
            mem_wdata <= merged;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_WR: begin
          state     <= S_RESP;
          mem_en    <= 1'b0;
          mem_wen   <= 1'b0;
          rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            if (q_partial && !(&rmw_count)) rmw_count <= rmw_count + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_en  <= 1'b0;
          mem_wen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rmw_initiator.sv
// Randomized bench for sram_rmw_initiator with a behavioural SRAM and a word-array reference model.
module tb_sram_rmw_initiator;
  import sram_ctrl_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  rmw_count;

  sram_rmw_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rmw_count (rmw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with a backdoor load port used only while the DUT is held in reset.
  logic [DATA_W-1:0] sram [512];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         mem_rdata <= sram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                c;
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } strobe_t;
  strobe_t slog[$];
  int  viol = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (mem_en) slog.push_back('{cyc, mem_wen, mem_addr, mem_wdata});
    if (mem_en && prev_en) viol = viol + 1;
    if (mem_wen && !mem_en) viol = viol + 1;
    prev_en = mem_en;
  end

  logic [DATA_W-1:0] ref_mem [512];
  int exp_rmw = 0;
  int n_pass  = 0;
  int n_chk   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic xact(input logic [ADDR_W-1:0] a, input bit we, input logic [BE_W-1:0] be,
                      input logic [DATA_W-1:0] wd, input int hold);
    int acc, rv, lat, nstb, base;
    bit got, partial, full;
    logic [DATA_W-1:0] old, exp_rd, nw;
    old     = ref_mem[a];
    partial = we && be != 4'h0 && be != BE_ALL;
    full    = we && be == BE_ALL;
    nw = old;
    if (we) for (int i = 0; i < BE_W; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
    if (!we)          begin exp_rd = old; lat = 3; nstb = 1; end
    else if (partial) begin exp_rd = old; lat = 4; nstb = 2; end
    else if (full)    begin exp_rd = '0;  lat = 2; nstb = 1; end
    else              begin exp_rd = '0;  lat = 1; nstb = 0; end

    @(negedge clk);
    req_addr = a; req_we = we; req_be = be; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check_val("accept", 32'(got), 32'd1);
    if (!got) begin req_valid = 1'b0; rsp_ready = 1'b1; return; end
    acc  = cyc;
    base = slog.size();
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin got = 1; break; end
      @(negedge clk);
    end
    check_val("rsp_wait", 32'(got), 32'd1);
    rv = cyc;
    check_val("rsp_latency", 32'(rv - acc), 32'(lat));
    check_val("rsp_rdata", rsp_rdata, exp_rd);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_val("bp_valid", 32'(rsp_valid), 32'd1);
        check_val("bp_rdata", rsp_rdata, exp_rd);
        check_val("bp_req_ready", 32'(req_ready), 32'd0);
        check_val("bp_mem_en", 32'(mem_en), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check_val("rsp_drop", 32'(rsp_valid), 32'd0);
    if (hold == 0) check_val("req_ready_next", 32'(req_ready), 32'd1);
    if (partial) exp_rmw++;
    check_val("rmw_count", 32'(rmw_count), 32'(exp_rmw));
    check_val("strobe_cnt", 32'(slog.size() - base), 32'(nstb));
    if (slog.size() - base == nstb && nstb > 0) begin
      check_val("strobe1_cyc", 32'(slog[base].c - acc), 32'd1);
      check_val("strobe1_wen", 32'(slog[base].w), 32'(full));
      check_val("strobe1_addr", 32'(slog[base].a), 32'(a));
      if (full) check_val("strobe1_data", slog[base].d, wd);
      if (nstb == 2) begin
        check_val("strobe2_cyc", 32'(slog[base+1].c - acc), 32'd3);
        check_val("strobe2_wen", 32'(slog[base+1].w), 32'd1);
        check_val("strobe2_data", slog[base+1].d, nw);
      end
    end
    ref_mem[a] = nw;
    check_val("sram_word", sram[a], nw);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check_val({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check_val({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    check_val({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_val({tag, "_rmw_count"}, 32'(rmw_count), 32'd0);
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, base, nwr;
    bit got;
    logic [DATA_W-1:0] old20;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_be = '0;
    req_wdata = '0; rsp_ready = 1'b1;

    for (int i = 0; i < 512; i++) load_word(ADDR_W'(i), DATA_W'($urandom));
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_req_ready", 32'(req_ready), 32'd1);

    reset = 1'b1;
    load_word(9'h1A5, 32'hDEADBEEF);
    load_word(9'h010, 32'hAABBCCDD);
    reset = 1'b0;

    xact(9'h1A5, 1'b0, 4'h0, 32'h0, 0);
    xact(9'h003, 1'b1, 4'hF, 32'h12345678, 0);
    xact(9'h003, 1'b0, 4'h0, 32'h0, 0);
    xact(9'h010, 1'b1, 4'h5, 32'h11223344, 0);
    check_val("rmw_word_0x010", sram[16], 32'hAA22CC44);
    xact(9'h055, 1'b1, 4'h0, 32'hCAFEF00D, 0);
    xact(9'h1A5, 1'b0, 4'h0, 32'h0, 5);

    // Reset asserted while the RMW sits in CAPT: the write must never happen.
    old20 = ref_mem[9'h020];
    @(negedge clk);
    req_addr = 9'h020; req_we = 1'b1; req_be = 4'h5; req_wdata = ~old20; req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check_val("rst_accept", 32'(got), 32'd1);
    acc  = cyc;
    base = slog.size();
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    exp_rmw = 0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_val("midrst_idle", 32'(req_ready), 32'd1);
    nwr = 0;
    for (int i = base; i < slog.size(); i++) if (slog[i].w) nwr++;
    check_val("midrst_no_write", 32'(nwr), 32'd0);
    check_val("midrst_word", sram[9'h020], old20);
    check_val("midrst_rmw_count", 32'(rmw_count), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      logic [BE_W-1:0]   be;
      int sel, hold;
      a   = ($urandom % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      sel = $urandom % 4;
      be  = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : BE_W'($urandom);
      hold = ($urandom % 5 == 0) ? $urandom_range(1, 4) : 0;
      xact(a, ($urandom % 2) == 1, be, $urandom, hold);
    end
    for (int a = 0; a < 16; a++) xact(ADDR_W'(a), 1'b0, 4'h0, 32'h0, 0);

    check_val("strobe_rules", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
